// File: rtl/icache_axi_reader_if.sv
// AXI4 read-address / read-data channel bundle used between the icache miss
// responder (master) and the system interconnect (slave).
interface icache_axi_reader_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/icache_axi_reader.sv
// Instruction-cache miss responder: turns a held miss request into one
// single-beat AXI4 read and returns the word with a one-cycle dok pulse.
module icache_axi_reader #(
    parameter logic [3:0] AXI_ID = 4'd0,
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inst_cache_req,
    input  logic [ADDR_W-1:0]   inst_cache_addr,
    output logic [DATA_W-1:0]   inst_cache_rdata,
    output logic                inst_cache_dok,
    output logic                axi_rd_err,
    icache_axi_reader_if.master axi
);
    typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] araddr_reg, araddr_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic              err_reg, err_next;
    logic              stale_reg, stale_next;
    logic              req_lost;
    logic              unused_rlast;

    // Single outstanding beat: rlast carries no extra information here.
    assign unused_rlast = axi.rlast;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            araddr_reg <= '0;
            rdata_reg  <= '0;
            err_reg    <= 1'b0;
            stale_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            araddr_reg <= araddr_next;
            rdata_reg  <= rdata_next;
            err_reg    <= err_next;
            stale_reg  <= stale_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        araddr_next = araddr_reg;
        rdata_next  = rdata_reg;
        err_next    = err_reg;
        stale_next  = stale_reg;
        // A dropped request or a new address (flush/branch) makes the in-flight read useless.
        req_lost    = !inst_cache_req || (inst_cache_addr != araddr_reg);

        case (state_reg)
            IDLE: begin
                if (inst_cache_req) begin
                    araddr_next = inst_cache_addr;
                    stale_next  = 1'b0;
                    state_next  = AR;
                end
            end
            AR: begin
                if (req_lost) stale_next = 1'b1;
                if (axi.arready) state_next = R;
            end
            R: begin
                if (req_lost) stale_next = 1'b1;
                if (axi.rvalid) begin
                    if (!(stale_reg || req_lost)) rdata_next = axi.rdata;
                    err_next   = (axi.rresp != 2'b00);
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // All outputs decode from registers only; no AXI input reaches an output combinationally.
        axi.arid         = AXI_ID;
        axi.araddr       = araddr_reg;
        axi.arlen        = 8'd0;
        axi.arsize       = 3'b010;
        axi.arburst      = 2'b01;
        axi.arvalid      = (state_reg == AR);
        axi.rready       = (state_reg == R);
        inst_cache_rdata = rdata_reg;
        inst_cache_dok   = (state_reg == DONE) && !stale_reg;
        axi_rd_err       = (state_reg == DONE) && !stale_reg && err_reg;
    end
endmodule

// File: tb/tb_icache_axi_reader.sv
// Self-checking bench for icache_axi_reader: a delay-configurable AXI slave plus
// scenario tasks whose expectations come from address/latency rules, not the RTL.
module tb_icache_axi_reader;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              inst_cache_req;
    logic [ADDR_W-1:0] inst_cache_addr;
    logic [DATA_W-1:0] inst_cache_rdata;
    logic              inst_cache_dok;
    logic              axi_rd_err;

    icache_axi_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

    icache_axi_reader #(.AXI_ID(4'd0), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .inst_cache_req   (inst_cache_req),
        .inst_cache_addr  (inst_cache_addr),
        .inst_cache_rdata (inst_cache_rdata),
        .inst_cache_dok   (inst_cache_dok),
        .axi_rd_err       (axi_rd_err),
        .axi              (axi.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Slave configuration and observation log
    int          ar_delay = 0;
    int          r_delay  = 0;
    logic [1:0]  resp_cfg = 2'b00;
    int          ar_count = 0;
    int          r_count  = 0;
    logic [31:0] ar_addr_log[$];
    logic [7:0]  last_arlen;
    logic [2:0]  last_arsize;
    logic [1:0]  last_arburst;
    logic [3:0]  last_arid;

    // Monitor state
    int          cyc = 0;
    bit          rst_edge = 1'b0;
    int          dok_total = 0;
    int          err_total = 0;
    int          err_wo_dok = 0;
    int          ar_unstable = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h2408_0001;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= reset;
    end

    // AXI slave: decisions are made just after the falling edge for the next rising edge.
    initial begin : slave
        int          s;
        int          cnt;
        bit          ar_pend;
        bit          r_pend;
        logic [31:0] req_addr;
        s = 0; cnt = 0; ar_pend = 0; r_pend = 0; req_addr = '0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (ar_pend) begin s = 1; cnt = 0; end
            if (r_pend)  begin s = 0; cnt = 0; end
            ar_pend = 0; r_pend = 0;
            axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
            if (reset) begin
                s = 0; cnt = 0;
            end else if (s == 0) begin
                if (axi.arvalid) begin
                    if (cnt >= ar_delay) begin
                        axi.arready = 1'b1; ar_pend = 1; req_addr = axi.araddr; ar_count++;
                        ar_addr_log.push_back(axi.araddr);
                        last_arlen = axi.arlen; last_arsize = axi.arsize;
                        last_arburst = axi.arburst; last_arid = axi.arid;
                    end else cnt++;
                end
            end else begin
                if (cnt >= r_delay) begin
                    axi.rvalid = 1'b1; axi.rlast = 1'b1;
                    axi.rdata = mem_word(req_addr); axi.rresp = resp_cfg;
                    r_pend = axi.rready;
                    if (r_pend) r_count++;
                end else cnt++;
            end
        end
    end

    // Pulse/stability monitor sampled on the falling edge.
    initial begin : monitor
        bit          pv;
        logic [31:0] pa;
        pv = 0; pa = '0;
        forever begin
            @(negedge clk);
            if (!rst_edge && pv && !axi.arready && (!axi.arvalid || axi.araddr != pa)) ar_unstable++;
            pv = axi.arvalid; pa = axi.araddr;
            if (inst_cache_dok) dok_total++;
            if (axi_rd_err) err_total++;
            if (axi_rd_err && !inst_cache_dok) err_wo_dok++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holds req until dok (then drops it, as the cache would after refilling) or the budget expires.
    task automatic run_req(input logic [31:0] a, input int budget, output bit got,
                           output int lat, output logic [31:0] d, output logic e);
        int c0;
        inst_cache_req = 1'b1; inst_cache_addr = a; c0 = cyc;
        got = 0; lat = -1; d = 'x; e = 1'bx;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (inst_cache_dok) begin
                got = 1; lat = cyc - c0; d = inst_cache_rdata; e = axi_rd_err;
                inst_cache_req = 1'b0;
            end
        end
        inst_cache_req = 1'b0;
        $display("txn addr=%h got=%0d lat=%0d data=%h err=%b", a, got, lat, d, e);
    endtask

    task automatic test_reset();
        reset = 1'b1; inst_cache_req = 1'b0; inst_cache_addr = '0;
        idle(3);
        n_checks++; if (axi.arvalid !== 1'b0) $display("FAIL reset_arvalid got %b want 0", axi.arvalid); else n_pass++;
        n_checks++; if (axi.rready !== 1'b0) $display("FAIL reset_rready got %b want 0", axi.rready); else n_pass++;
        n_checks++; if (inst_cache_dok !== 1'b0) $display("FAIL reset_dok got %b want 0", inst_cache_dok); else n_pass++;
        n_checks++; if (axi_rd_err !== 1'b0) $display("FAIL reset_err got %b want 0", axi_rd_err); else n_pass++;
        n_checks++; if (axi.araddr !== 32'h0) $display("FAIL reset_araddr got %h want 0", axi.araddr); else n_pass++;
        n_checks++; if (inst_cache_rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", inst_cache_rdata); else n_pass++;
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_zero_wait();
        bit got; int lat; logic [31:0] d; logic e; int n0; int d0;
        ar_delay = 0; r_delay = 0; resp_cfg = 2'b00;
        n0 = ar_addr_log.size(); d0 = dok_total;
        inst_cache_req = 1'b1; inst_cache_addr = 32'hBFC0_0000;
        @(negedge clk);
        n_checks++; if (axi.arvalid !== 1'b1) $display("FAIL zw_arvalid_cycle1 got %b want 1", axi.arvalid); else n_pass++;
        // One cycle already elapsed, so dok in cycle 3 means two more.
        run_req(32'hBFC0_0000, 10, got, lat, d, e);
        n_checks++; if (lat !== 2) $display("FAIL zw_latency got %0d want 2 more cycles", lat); else n_pass++;
        n_checks++; if (d !== 32'h2408_0001) $display("FAIL zw_rdata got %h want 24080001", d); else n_pass++;
        n_checks++; if (e !== 1'b0) $display("FAIL zw_err got %b want 0", e); else n_pass++;
        n_checks++; if (ar_addr_log.size() != n0 + 1 || ar_addr_log[n0] !== 32'hBFC0_0000)
            $display("FAIL zw_araddr got %0d reads want 1 at bfc00000", ar_addr_log.size() - n0); else n_pass++;
        n_checks++; if ({last_arid, last_arlen, last_arsize, last_arburst} !== {4'd0, 8'd0, 3'b010, 2'b01})
            $display("FAIL zw_ar_fields got id=%h len=%h size=%h burst=%h want 0/0/2/1",
                     last_arid, last_arlen, last_arsize, last_arburst); else n_pass++;
        idle(4);
        n_checks++; if (dok_total - d0 != 1) $display("FAIL zw_dok_count got %0d want 1", dok_total - d0); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit got; int lat; logic [31:0] d; logic e; int d0; int u0;
        ar_delay = 5; r_delay = 4; resp_cfg = 2'b00;
        d0 = dok_total; u0 = ar_unstable;
        run_req(32'h0000_1240, 40, got, lat, d, e);
        n_checks++; if (lat !== 12) $display("FAIL bp_latency got %0d want 12", lat); else n_pass++;
        n_checks++; if (d !== mem_word(32'h0000_1240)) $display("FAIL bp_rdata got %h want %h", d, mem_word(32'h0000_1240)); else n_pass++;
        idle(4);
        n_checks++; if (dok_total - d0 != 1) $display("FAIL bp_dok_count got %0d want 1", dok_total - d0); else n_pass++;
        n_checks++; if (ar_unstable != u0) $display("FAIL bp_ar_stable got %0d violations want 0", ar_unstable - u0); else n_pass++;
    endtask

    task automatic test_flush();
        bit got; int lat; logic [31:0] d; logic e; int d0; int r0; bit seen;
        ar_delay = 0; r_delay = 3; resp_cfg = 2'b00;
        d0 = dok_total; r0 = r_count; seen = 0;
        inst_cache_req = 1'b1; inst_cache_addr = 32'h0000_3000;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (axi.rready) seen = 1;
        end
        n_checks++; if (!seen) $display("FAIL fl_reach_r got 0 want rready within 10 cycles"); else n_pass++;
        inst_cache_req = 1'b0;
        idle(10);
        n_checks++; if (dok_total != d0) $display("FAIL fl_no_dok got %0d want 0", dok_total - d0); else n_pass++;
        n_checks++; if (r_count - r0 != 1) $display("FAIL fl_beat_taken got %0d want 1", r_count - r0); else n_pass++;
        n_checks++; if ({axi.arvalid, axi.rready} !== 2'b00) $display("FAIL fl_idle got %b want 00", {axi.arvalid, axi.rready}); else n_pass++;
        r_delay = 0;
        run_req(32'h0000_3004, 10, got, lat, d, e);
        n_checks++; if (lat !== 3 || d !== mem_word(32'h0000_3004))
            $display("FAIL fl_next_req got lat=%0d data=%h want 3/%h", lat, d, mem_word(32'h0000_3004)); else n_pass++;
        idle(2);
    endtask

    task automatic test_addr_change();
        bit got; int lat; logic [31:0] d; logic e; int n0; int d0; int u0; bit seen;
        ar_delay = 3; r_delay = 1; resp_cfg = 2'b00;
        n0 = ar_addr_log.size(); d0 = dok_total; u0 = ar_unstable; seen = 0;
        inst_cache_req = 1'b1; inst_cache_addr = 32'h0000_0100;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            if (axi.arvalid) seen = 1;
        end
        inst_cache_addr = 32'h0000_0200;
        run_req(32'h0000_0200, 40, got, lat, d, e);
        n_checks++; if (!got || d !== mem_word(32'h0000_0200))
            $display("FAIL ac_rdata got %h want %h", d, mem_word(32'h0000_0200)); else n_pass++;
        n_checks++; if (ar_addr_log.size() != n0 + 2)
            $display("FAIL ac_read_count got %0d want 2", ar_addr_log.size() - n0); else n_pass++;
        if (ar_addr_log.size() == n0 + 2) begin
            n_checks++; if (ar_addr_log[n0] !== 32'h100) $display("FAIL ac_first_araddr got %h want 100", ar_addr_log[n0]); else n_pass++;
            n_checks++; if (ar_addr_log[n0+1] !== 32'h200) $display("FAIL ac_second_araddr got %h want 200", ar_addr_log[n0+1]); else n_pass++;
        end
        idle(4);
        n_checks++; if (dok_total - d0 != 1) $display("FAIL ac_dok_count got %0d want 1", dok_total - d0); else n_pass++;
        n_checks++; if (ar_unstable != u0) $display("FAIL ac_ar_stable got %0d violations want 0", ar_unstable - u0); else n_pass++;
    endtask

    task automatic test_error();
        bit got; int lat; logic [31:0] d; logic e; int e0;
        ar_delay = 1; r_delay = 2; resp_cfg = 2'b10;
        e0 = err_total;
        run_req(32'h0000_5550, 20, got, lat, d, e);
        n_checks++; if (!got || e !== 1'b1) $display("FAIL er_err_with_dok got got=%0d err=%b want 1/1", got, e); else n_pass++;
        n_checks++; if (lat !== 6) $display("FAIL er_latency got %0d want 6", lat); else n_pass++;
        idle(4);
        n_checks++; if (err_total - e0 != 1) $display("FAIL er_pulse_width got %0d cycles want 1", err_total - e0); else n_pass++;
        resp_cfg = 2'b00;
    endtask

    task automatic test_reset_mid();
        bit got; int lat; logic [31:0] d; logic e; bit seen;
        ar_delay = 0; r_delay = 5; resp_cfg = 2'b00; seen = 0;
        inst_cache_req = 1'b1; inst_cache_addr = 32'h0000_4000;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (axi.rready) seen = 1;
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if ({axi.arvalid, axi.rready, inst_cache_dok} !== 3'b000)
            $display("FAIL rm_outputs got %b want 000", {axi.arvalid, axi.rready, inst_cache_dok}); else n_pass++;
        n_checks++; if (axi.araddr !== 32'h0) $display("FAIL rm_araddr got %h want 0", axi.araddr); else n_pass++;
        reset = 1'b0; r_delay = 0;
        run_req(32'h0000_4000, 10, got, lat, d, e);
        n_checks++; if (lat !== 3 || d !== mem_word(32'h0000_4000))
            $display("FAIL rm_restart got lat=%0d data=%h want 3/%h", lat, d, mem_word(32'h0000_4000)); else n_pass++;
        idle(2);
    endtask

    task automatic test_random();
        bit got; int lat; logic [31:0] d; logic e;
        logic [31:0] a; int ard; int rd; logic [1:0] rs;
        for (int t = 0; t < 20; t++) begin
            a = $urandom() & 32'hFFFF_FFFC;
            ard = $urandom_range(0, 4); rd = $urandom_range(0, 4); rs = 2'($urandom_range(0, 3));
            ar_delay = ard; r_delay = rd; resp_cfg = rs;
            run_req(a, 30, got, lat, d, e);
            n_checks++; if (lat !== 3 + ard + rd) $display("FAIL rnd_latency[%0d] got %0d want %0d", t, lat, 3 + ard + rd); else n_pass++;
            n_checks++; if (d !== mem_word(a)) $display("FAIL rnd_rdata[%0d] got %h want %h", t, d, mem_word(a)); else n_pass++;
            n_checks++; if (e !== (rs != 2'b00)) $display("FAIL rnd_err[%0d] got %b want %b", t, e, rs != 2'b00); else n_pass++;
            idle($urandom_range(1, 3));
        end
        resp_cfg = 2'b00;
    endtask

    task automatic test_pulse_rules();
        n_checks++; if (err_wo_dok != 0) $display("FAIL pr_err_without_dok got %0d want 0", err_wo_dok); else n_pass++;
        n_checks++; if (ar_unstable != 0) $display("FAIL pr_ar_stable got %0d violations want 0", ar_unstable); else n_pass++;
    endtask

    initial begin
        reset = 1'b1; inst_cache_req = 1'b0; inst_cache_addr = '0;
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_flush();
        test_addr_change();
        test_error();
        test_reset_mid();
        test_random();
        test_pulse_rules();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
